// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg: shared types and constants for the MIPS writeback sequencer
package mips_wb_pkg;
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LINK = 2'd2,
    WB_LOAD = 2'd3
  } wb_source_t;
  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LBU = 3'd1,
    LD_LH  = 3'd2,
    LD_LHU = 3'd3,
    LD_LW  = 3'd4,
    LD_LWL = 3'd5,
    LD_LWR = 3'd6
  } load_type_t;
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_WRITE    = 2'd2
  } wb_state_t;
  localparam logic [31:0] LINK_OFFSET = 32'd8;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
endpackage

// File: rtl/mips_load_align.sv
// mips_load_align: little-endian load alignment, extension and LWL/LWR merge
module mips_load_align
  import mips_wb_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  offset_i,
  input  load_type_t  load_type_i,
  input  logic [31:0] rt_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [4:0]  sh;
  logic [5:0]  sh_mask;
  assign sh      = {offset_i, 3'b000};
  assign sh_mask = {1'b0, sh} + 6'd8;
  assign b       = raw_i[sh +: 8];
  assign h       = offset_i[1] ? raw_i[31:16] : raw_i[15:0];
  // pick the aligned value; a 32-bit shift of the LWL mask (o=3) yields zero
  always_comb begin
    data_o = raw_i;
    case (load_type_i)
      LD_LB:   data_o = {{24{b[7]}}, b};
      LD_LBU:  data_o = {24'd0, b};
      LD_LH:   data_o = {{16{h[15]}}, h};
      LD_LHU:  data_o = {16'd0, h};
      LD_LWL:  data_o = (raw_i << (5'd24 - sh)) | (rt_i & (ONES >> sh_mask));
      LD_LWR:  data_o = (raw_i >> sh) | (rt_i & ~(ONES >> sh));
      default: data_o = raw_i;
    endcase
  end
endmodule

// File: rtl/mips_writeback.sv
// mips_writeback: sequences one committed result per request into the register file
module mips_writeback
  import mips_wb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  wb_source,
  input  logic [4:0]  dest_index,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc,
  input  logic [2:0]  load_type,
  input  logic [31:0] old_rt_data,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        mem_read,
  output logic [31:0] mem_address,
  output logic        write_enable,
  output logic [4:0]  write_register,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        done
);
  wb_source_t  src;
  wb_state_t   state_q, state_d;
  load_type_t  ld_q, ld_d;
  logic [4:0]  dest_q, dest_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rt_q, rt_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        write_enable_q, write_enable_d;
  logic [4:0]  write_register_q, write_register_d;
  logic [31:0] write_data_q, write_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] aligned;
  assign src = wb_source_t'(wb_source);
  mips_load_align u_align (
    .raw_i       (mem_readdata),
    .offset_i    (off_q),
    .load_type_i (ld_q),
    .rt_i        (rt_q),
    .data_o      (aligned)
  );
  // next state; every output is computed one cycle ahead so it leaves a flop
  always_comb begin
    state_d          = state_q;
    dest_d           = dest_q;
    ld_d             = ld_q;
    off_d            = off_q;
    rt_d             = rt_q;
    mem_read_d       = 1'b0;
    mem_address_d    = '0;
    write_enable_d   = 1'b0;
    write_register_d = '0;
    write_data_d     = '0;
    busy_d           = 1'b0;
    done_d           = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        dest_d = dest_index;
        ld_d   = load_type_t'(load_type);
        off_d  = alu_result[1:0];
        rt_d   = old_rt_data;
        case (src)
          WB_ALU, WB_LINK: begin
            state_d          = S_WRITE;
            write_enable_d   = |dest_index;
            write_register_d = dest_index;
            write_data_d     = src == WB_LINK ? pc + LINK_OFFSET : alu_result;
            done_d           = 1'b1;
            busy_d           = 1'b1;
          end
          WB_LOAD: begin
            state_d       = S_MEM_READ;
            mem_read_d    = 1'b1;
            mem_address_d = {alu_result[31:2], 2'b00};
            busy_d        = 1'b1;
          end
          default: done_d = 1'b1;
        endcase
      end
      S_MEM_READ: begin
        busy_d = 1'b1;
        if (mem_waitrequest) begin
          mem_read_d    = 1'b1;
          mem_address_d = mem_address_q;
        end else begin
          state_d          = S_WRITE;
          write_enable_d   = |dest_q;
          write_register_d = dest_q;
          write_data_d     = aligned;
          done_d           = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and output registers; reset abandons any in-flight request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      dest_q           <= '0;
      ld_q             <= LD_LB;
      off_q            <= '0;
      rt_q             <= '0;
      mem_read_q       <= 1'b0;
      mem_address_q    <= '0;
      write_enable_q   <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      dest_q           <= dest_d;
      ld_q             <= ld_d;
      off_q            <= off_d;
      rt_q             <= rt_d;
      mem_read_q       <= mem_read_d;
      mem_address_q    <= mem_address_d;
      write_enable_q   <= write_enable_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end
  assign mem_read       = mem_read_q;
  assign mem_address    = mem_address_q;
  assign write_enable   = write_enable_q;
  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule
